// File: rtl/tb_run_monitor.sv
// Bench run controller: snoops retire/writeback, detects halt or watchdog expiry, drains, then reports.
// All outputs registered; done rises on the edge after the last drain cycle and stays until rst.
module tb_run_monitor #(
    parameter int          LANES          = 1,
    parameter int          CNT_W          = 32,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          DRAIN_CYCLES   = 8,
    parameter logic [31:0] PASS_VALUE     = 32'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_en,
    input  logic [LANES-1:0]      retire_valid,
    input  logic [32*LANES-1:0]   retire_inst,
    input  logic [LANES-1:0]      wb_we,
    input  logic [5*LANES-1:0]    wb_rd,
    input  logic [32*LANES-1:0]   wb_data,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [1:0]            halt_cause,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      instret,
    output logic [31:0]           a0_value
);
    localparam logic [31:0] ECALL_W  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_W = 32'h0010_0073;
    localparam logic [31:0] JSELF_W  = 32'h0000_006F;
    localparam int          DW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t            state;
    logic [DW-1:0]     drain_cnt;

    logic              halt_found;
    logic [1:0]        cause_n;
    logic [CNT_W-1:0]  pop;
    logic [31:0]       a0_n;
    logic [31:0]       lane_inst;
    logic [CNT_W:0]    cyc_sum;
    logic [CNT_W:0]    inst_sum;
    logic [CNT_W-1:0]  cyc_n;
    logic [CNT_W-1:0]  inst_n;
    logic              timeout_hit;
    logic              pass_n;

    // Lanes are scanned oldest first; the halting lane itself still counts and writes back.
    always_comb begin
        halt_found = 1'b0;
        cause_n    = 2'd0;
        pop        = '0;
        a0_n       = a0_value;
        lane_inst  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_inst = retire_inst[32*i +: 32];
            if (!halt_found) begin
                if (retire_valid[i])
                    pop = pop + CNT_W'(1);
                if (wb_we[i] && wb_rd[5*i +: 5] == 5'd10)
                    a0_n = wb_data[32*i +: 32];
                if (retire_valid[i]) begin
                    if (lane_inst == ECALL_W) begin
                        halt_found = 1'b1;
                        cause_n    = 2'd1;
                    end else if (lane_inst == EBREAK_W) begin
                        halt_found = 1'b1;
                        cause_n    = 2'd2;
                    end else if (lane_inst == JSELF_W) begin
                        halt_found = 1'b1;
                        cause_n    = 2'd3;
                    end
                end
            end
        end
    end

    assign cyc_sum     = {1'b0, cycle_count} + {{CNT_W{1'b0}}, 1'b1};
    assign inst_sum    = {1'b0, instret} + {1'b0, pop};
    assign cyc_n       = cyc_sum[CNT_W]  ? '1 : cyc_sum[CNT_W-1:0];
    assign inst_n      = inst_sum[CNT_W] ? '1 : inst_sum[CNT_W-1:0];
    assign timeout_hit = (cyc_n >= CNT_W'(TIMEOUT_CYCLES));
    assign pass_n      = (cause_n == 2'd1) && (a0_n == PASS_VALUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            halt_cause  <= 2'd0;
            cycle_count <= '0;
            instret     <= '0;
            a0_value    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_en)
                        state <= RUN;
                end
                RUN: begin
                    if (run_en) begin
                        cycle_count <= cyc_n;
                        instret     <= inst_n;
                        a0_value    <= a0_n;
                        // A halt in the watchdog's final cycle takes priority over the timeout.
                        if (halt_found) begin
                            halt_cause <= cause_n;
                            if (DRAIN_CYCLES == 0) begin
                                state <= FIN;
                                done  <= 1'b1;
                                pass  <= pass_n;
                            end else begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end
                        end else if (timeout_hit) begin
                            state   <= FIN;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        state <= FIN;
                        done  <= 1'b1;
                        pass  <= (halt_cause == 2'd1) && (a0_value == PASS_VALUE);
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tb_run_monitor.sv
// Self-checking bench for tb_run_monitor: table of halt scenarios plus timeout, pause and reset sequences.
module tb_tb_run_monitor;
    localparam int          LANES   = 2;
    localparam int          CNT_W   = 32;
    localparam int          TMO     = 50;
    localparam int          DRAIN   = 8;
    localparam logic [31:0] ECALL   = 32'h0000_0073;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [31:0] JSELF   = 32'h0000_006F;
    localparam logic [31:0] ADDI    = 32'h0010_0093;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              run_en = 1'b0;
    logic [LANES-1:0]  retire_valid = '0;
    logic [63:0]       retire_inst = '0;
    logic [LANES-1:0]  wb_we = '0;
    logic [9:0]        wb_rd = '0;
    logic [63:0]       wb_data = '0;
    logic              done, pass, timeout;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  cycle_count, instret;
    logic [31:0]       a0_value;

    always #5 clk = ~clk;

    tb_run_monitor #(
        .LANES(LANES), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO),
        .DRAIN_CYCLES(DRAIN), .PASS_VALUE(32'd0)
    ) dut (
        .clk(clk), .rst(rst), .run_en(run_en),
        .retire_valid(retire_valid), .retire_inst(retire_inst),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .pass(pass), .timeout(timeout), .halt_cause(halt_cause),
        .cycle_count(cycle_count), .instret(instret), .a0_value(a0_value)
    );

    typedef struct {
        int          n_pre;
        logic        v0;
        logic [31:0] i0;
        logic        we0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] i1;
        logic        we1;
        logic [31:0] d1;
        logic        e_pass;
        logic [1:0]  e_cause;
        int          e_cyc;
        int          e_inst;
        logic [31:0] e_a0;
    } vec_t;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [1:0]  cause;
        int          cyc;
        int          inst;
        logic [31:0] a0;
        int          lat;
    } exp_t;

    vec_t vecs[8];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        retire_valid = '0;
        retire_inst  = '0;
        wb_we        = '0;
        wb_rd        = '0;
        wb_data      = '0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        run_en = 1'b0;
        clear_lanes();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic compare_out(input string tag, input int lat);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.queue: got empty, want entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".lat"},     64'(lat),         64'(e.lat));
            chk({tag, ".done"},    64'(done),        64'd1);
            chk({tag, ".pass"},    64'(pass),        64'(e.pass));
            chk({tag, ".timeout"}, 64'(timeout),     64'(e.timeout));
            chk({tag, ".cause"},   64'(halt_cause),  64'(e.cause));
            chk({tag, ".cycles"},  64'(cycle_count), 64'(e.cyc));
            chk({tag, ".instret"}, 64'(instret),     64'(e.inst));
            chk({tag, ".a0"},      64'(a0_value),    64'(e.a0));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        do_reset();
        run_en = 1'b1;
        tick();
        for (int k = 0; k < v.n_pre; k++) begin
            retire_valid = 2'b01;
            retire_inst  = {32'h0, ADDI};
            tick();
        end
        retire_valid = {v.v1, v.v0};
        retire_inst  = {v.i1, v.i0};
        wb_we        = {v.we1, v.we0};
        wb_rd        = {5'd10, v.rd0};
        wb_data      = {v.d1, v.d0};
        exp_q.push_back('{v.e_pass, 1'b0, v.e_cause, v.e_cyc, v.e_inst, v.e_a0, DRAIN});
        tick();
        clear_lanes();
        wait_done(lat);
        compare_out(tag, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        int lat;
        //          pre v0 i0      we0 rd0   d0     v1 i1     we1 d1     pass cause cyc inst a0
        vecs[0] = '{5,  1, ECALL,  1, 5'd10, 32'd0, 0, 32'h0, 0, 32'd0, 1, 2'd1, 6,  6,  32'd0};
        vecs[1] = '{5,  1, ECALL,  1, 5'd10, 32'd3, 0, 32'h0, 0, 32'd0, 0, 2'd1, 6,  6,  32'd3};
        vecs[2] = '{2,  1, EBREAK, 0, 5'd10, 32'd0, 1, ADDI,  1, 32'd7, 0, 2'd2, 3,  3,  32'd0};
        vecs[3] = '{0,  1, ADDI,   1, 5'd10, 32'd5, 1, JSELF, 1, 32'd9, 0, 2'd3, 1,  2,  32'd9};
        vecs[4] = '{3,  1, ECALL,  1, 5'd10, 32'd0, 1, ECALL, 1, 32'd4, 1, 2'd1, 4,  4,  32'd0};
        vecs[5] = '{1,  0, ECALL,  0, 5'd10, 32'd0, 1, EBREAK,0, 32'd0, 0, 2'd2, 2,  2,  32'd0};
        vecs[6] = '{2,  1, ECALL,  1, 5'd0,  32'd5, 0, 32'h0, 0, 32'd0, 1, 2'd1, 3,  3,  32'd0};
        vecs[7] = '{49, 1, ECALL,  1, 5'd10, 32'd0, 0, 32'h0, 0, 32'd0, 1, 2'd1, 50, 50, 32'd0};

        #2 rst = 1'b1;
        #1;
        chk("rst.done",   64'(done),        64'd0);
        chk("rst.cycles", 64'(cycle_count), 64'd0);
        chk("rst.cause",  64'(halt_cause),  64'd0);
        do_reset();
        tick();
        tick();
        chk("idle.cycles", 64'(cycle_count), 64'd0);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("V%0d", i));

        // Watchdog expiry with no halt.
        do_reset();
        run_en = 1'b1;
        tick();
        exp_q.push_back('{1'b0, 1'b1, 2'd0, TMO, 0, 32'd0, TMO});
        wait_done(lat);
        compare_out("T3", lat);

        // Pause mid-run: halts and writebacks offered while run_en=0 must be ignored.
        do_reset();
        run_en = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            retire_valid = 2'b01;
            retire_inst  = {32'h0, ADDI};
            tick();
        end
        run_en       = 1'b0;
        retire_valid = 2'b01;
        retire_inst  = {32'h0, ECALL};
        wb_we        = 2'b01;
        wb_rd        = {5'd0, 5'd10};
        wb_data      = {32'd0, 32'd1};
        for (int k = 0; k < 10; k++) tick();
        chk("T5.frozen_cycles", 64'(cycle_count), 64'd3);
        chk("T5.frozen_inst",   64'(instret),     64'd3);
        chk("T5.frozen_a0",     64'(a0_value),    64'd0);
        chk("T5.frozen_done",   64'(done),        64'd0);
        clear_lanes();
        run_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            retire_valid = 2'b01;
            retire_inst  = {32'h0, ADDI};
            tick();
        end
        retire_valid = 2'b01;
        retire_inst  = {32'h0, ECALL};
        wb_we        = 2'b01;
        wb_rd        = {5'd0, 5'd10};
        wb_data      = '0;
        exp_q.push_back('{1'b1, 1'b0, 2'd1, 6, 6, 32'd0, DRAIN});
        tick();
        clear_lanes();
        wait_done(lat);
        compare_out("T5", lat);

        // Asynchronous reset while draining, then a clean rerun.
        do_reset();
        run_en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            retire_valid = 2'b01;
            retire_inst  = {32'h0, ADDI};
            tick();
        end
        retire_valid = 2'b01;
        retire_inst  = {32'h0, ECALL};
        tick();
        clear_lanes();
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("T6.async_done",   64'(done),        64'd0);
        chk("T6.async_cycles", 64'(cycle_count), 64'd0);
        chk("T6.async_inst",   64'(instret),     64'd0);
        chk("T6.async_cause",  64'(halt_cause),  64'd0);
        run_vec(vecs[0], "T6");

        // DONE is terminal: further retires and halts change nothing.
        run_en       = 1'b1;
        retire_valid = 2'b11;
        retire_inst  = {ADDI, ECALL};
        for (int k = 0; k < 5; k++) tick();
        chk("sticky.done",   64'(done),        64'd1);
        chk("sticky.cycles", 64'(cycle_count), 64'd6);
        chk("sticky.inst",   64'(instret),     64'd6);
        chk("sticky.pass",   64'(pass),        64'd1);
        clear_lanes();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
